// File: rtl/des_key_sched.sv
// Sequential DES key schedule: emits the 16 round subkeys one per valid/ready handshake.
// Encrypt order K1..K16 uses left rotations of C/D; decrypt order K16..K1 uses right rotations.
module des_key_sched #(
  parameter int unsigned PARITY_CHK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [64:1] key,
  output logic [48:1] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [4:1]  round,
  output logic        busy,
  output logic        done,
  output logic        key_par_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Bit n of every vector is DES bit n, so the tables index directly.
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [56:1] pc1(input logic [64:1] k);
    logic [56:1] r;
    r = '0;
    for (int unsigned i = 1; i <= 56; i++) r[i] = k[PC1[i-1]];
    return r;
  endfunction

  // DES "left" moves bit n+1 into bit n, i.e. toward the low index here.
  function automatic logic [28:1] rot(input logic [28:1] v, input logic right, input logic two);
    logic [28:1] r;
    case ({right, two})
      2'b00:   r = {v[1],     v[28:2]};
      2'b01:   r = {v[2:1],   v[28:3]};
      2'b10:   r = {v[27:1],  v[28]};
      default: r = {v[26:1],  v[28:27]};
    endcase
    return r;
  endfunction

  function automatic logic par_err(input logic [64:1] k);
    logic e;
    e = 1'b0;
    for (int unsigned b = 0; b < 8; b++) e = e | ~(^k[8*b+1 +: 8]);
    return e;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [28:1] c_q, c_d;
  logic [28:1] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic        par_q, par_d;

  logic [56:1] cd_ld;
  logic [56:1] cd;
  logic        two;

  assign cd = {d_q, c_q};

  always_comb begin
    subkey = '0;
    for (int unsigned i = 1; i <= 48; i++) subkey[i] = cd[PC2[i-1]];
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    mode_d  = mode_q;
    par_d   = par_q;
    cd_ld   = pc1(key);
    // Single-bit steps lead into outputs 1, 8 and 15 in both directions.
    two     = !((round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14));
    case (state_q)
      IDLE: begin
        if (start) begin
          c_d     = decrypt ? cd_ld[28:1]  : rot(cd_ld[28:1], 1'b0, 1'b0);
          d_d     = decrypt ? cd_ld[56:29] : rot(cd_ld[56:29], 1'b0, 1'b0);
          round_d = 4'd0;
          mode_d  = decrypt;
          par_d   = (PARITY_CHK != 0) && par_err(key);
          state_d = RUN;
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (round_q == 4'd15) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
            c_d     = rot(c_q, mode_q, two);
            d_d     = rot(d_q, mode_q, two);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
    end
  end

  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign round        = round_q;
  assign key_par_err  = par_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched: classic key 133457799BBCDFF1 schedule in both orders,
// backpressure, ignored start, async reset abort, and key parity flag.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [64:1] key;
  logic        subkey_ready;
  logic [48:1] subkey;
  logic        subkey_valid;
  logic [4:1]  round;
  logic        busy;
  logic        done;
  logic        key_par_err;

  logic [48:1] np_subkey;
  logic        np_valid;
  logic [4:1]  np_round;
  logic        np_busy;
  logic        np_done;
  logic        np_par;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;

  // K1..K16 for KEY_STD, DES bit 1 first.
  logic [47:0] KT [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  always #5 clk = ~clk;

  des_key_sched #(.PARITY_CHK(1)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .busy         (busy),
    .done         (done),
    .key_par_err  (key_par_err)
  );

  des_key_sched #(.PARITY_CHK(0)) u_np (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .subkey       (np_subkey),
    .subkey_valid (np_valid),
    .subkey_ready (subkey_ready),
    .round        (np_round),
    .busy         (np_busy),
    .done         (np_done),
    .key_par_err  (np_par)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [64:1] rev64(input logic [63:0] h);
    logic [64:1] r;
    for (int i = 1; i <= 64; i++) r[i] = h[64-i];
    return r;
  endfunction

  function automatic logic [48:1] rev48(input logic [47:0] h);
    logic [48:1] r;
    for (int i = 1; i <= 48; i++) r[i] = h[48-i];
    return r;
  endfunction

  task automatic run_sched(input logic dec, input logic [63:0] kh, input bit bp, input bit inj,
                           input bit zero_exp, input logic exp_par, input logic exp_np_par);
    int          n;
    int          cyc;
    int          vcnt;
    bit          acc;
    bit          injected;
    logic        rdy;
    logic [47:0] e;
    key = rev64(kh);
    decrypt = dec;
    start = 1'b1;
    subkey_ready = 1'b1;
    @(negedge clk);
    // Scramble inputs after start: the captured key/mode must not follow them.
    start = 1'b0;
    key = '1;
    decrypt = ~dec;
    check("first_valid", 64'(subkey_valid), 64'd1);
    check("par_err", 64'(key_par_err), 64'(exp_par));
    check("np_par_err", 64'(np_par), 64'(exp_np_par));
    n = 0;
    cyc = 0;
    vcnt = 0;
    injected = 1'b0;
    while (n < 16 && cyc < 300) begin
      check("valid", 64'(subkey_valid), 64'd1);
      if (!subkey_valid) break;
      vcnt++;
      check("busy", 64'(busy), 64'd1);
      check("round", 64'(round), 64'(n));
      e = zero_exp ? 48'h0 : KT[dec ? 15 - n : n];
      check("subkey", 64'(subkey), 64'(rev48(e)));
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inj && !injected && n == 5) begin
        start = 1'b1;
        key = '0;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      subkey_ready = rdy;
      acc = subkey_valid && rdy;
      @(negedge clk);
      cyc++;
      if (acc) n++;
    end
    start = 1'b0;
    check("accepts", 64'(n), 64'd16);
    if (!bp) check("valid_cycles", 64'(vcnt), 64'd16);
    check("done_pulse", 64'(done), 64'd1);
    check("done_valid", 64'(subkey_valid), 64'd0);
    check("done_busy", 64'(busy), 64'd0);
    check("par_hold", 64'(key_par_err), 64'(exp_par));
    // start during DONE must be dropped.
    subkey_ready = 1'b0;
    start = 1'b1;
    key = rev64(kh);
    @(negedge clk);
    start = 1'b0;
    check("done_cleared", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(subkey_valid), 64'd0);
    @(negedge clk);
  endtask

  task automatic reset_abort();
    int cyc;
    key = rev64(KEY_STD);
    decrypt = 1'b0;
    start = 1'b1;
    subkey_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (round != 4'd7 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_r7", 64'(round), 64'd7);
    check("r7_valid", 64'(subkey_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(subkey_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_round", 64'(round), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", 64'(subkey_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    decrypt = 1'b0;
    key = '0;
    subkey_ready = 1'b0;
    @(negedge clk);
    check("reset_valid", 64'(subkey_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_round", 64'(round), 64'd0);
    check("reset_subkey", 64'(subkey), 64'd0);
    check("reset_par", 64'(key_par_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", 64'(subkey_valid), 64'd0);

    // Every byte of KEY_STD has odd parity, so no parity flag.
    run_sched(1'b0, KEY_STD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_sched(1'b1, KEY_STD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_sched(1'b0, KEY_STD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_sched(1'b1, KEY_STD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_sched(1'b0, KEY_STD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    reset_abort();
    run_sched(1'b0, KEY_STD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Only parity bits set: PC-1 sees an all-zero key.
    run_sched(1'b0, 64'h0101010101010101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_sched(1'b1, 64'h0000000000000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
